// File: rtl/cl_mask_gen_pkg.sv
// Shared constants, FSM state type and a leading-bit counter reference
// for the canonical-mask generator and its partners.
package cl_pkg;

  localparam int WIDTH = 32;
  localparam int CW    = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Leading-bit counter: number of MSB-first positions equal to b.
  function automatic int unsigned count_ref(logic [WIDTH-1:0] value, logic b);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (run && (value[WIDTH-1-i] == b)) n++;
      else run = 1'b0;
    end
    return n;
  endfunction

endpackage

// File: rtl/cl_mask_gen_if.sv
// Request/response bundle for cl_mask_gen: request side is the master.
interface cl_mask_gen_if #(
  parameter int WIDTH = cl_pkg::WIDTH,
  parameter int CW    = cl_pkg::CW
);
  logic             start;
  logic [CW-1:0]    count;
  logic             lead_bit;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;

  modport master (
    output start, count, lead_bit,
    input  ready, done, result, ovf
  );

  modport slave (
    input  start, count, lead_bit,
    output ready, done, result, ovf
  );
endinterface

// File: rtl/cl_mask_step.sv
// One barrel stage: optionally shift acc right by 2^k, filling vacated
// MSBs with the polarity bit.
module cl_mask_step #(
  parameter int WIDTH = cl_pkg::WIDTH,
  parameter int CW    = cl_pkg::CW,
  parameter int KW    = $clog2(CW)
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [KW-1:0]    k_i,
  input  logic             sel_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] acc_o
);

  logic [CW-1:0]    sh;
  logic [WIDTH-1:0] fill_mask;

  // A shift of WIDTH empties both terms, giving an all-fill word.
  always_comb begin
    sh        = CW'(1) << k_i;
    fill_mask = ~({WIDTH{1'b1}} >> sh);
    acc_o     = sel_i ? ((acc_i >> sh) | (fill_mask & {WIDTH{fill_i}})) : acc_i;
  end

endmodule

// File: rtl/cl_mask_gen.sv
// Iterative canonical-word generator: n leading copies of the polarity bit,
// one count bit resolved per cycle MSB first, fixed CW-cycle latency.
module cl_mask_gen
  import cl_pkg::*;
#(
  parameter int WIDTH = cl_pkg::WIDTH,
  parameter int CW    = cl_pkg::CW
) (
  input  logic           clk,
  input  logic           rst,
  cl_mask_gen_if.slave   bus
);

  localparam int KW = $clog2(CW);
  localparam logic [CW-1:0] WMAX = CW'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [KW-1:0]    step_q, step_d;
  logic [CW-1:0]    n_q, n_d;
  logic             b_q, b_d;
  logic             ovfp_q, ovfp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_acc;

  cl_mask_step #(.WIDTH(WIDTH), .CW(CW), .KW(KW)) u_step (
    .acc_i  (acc_q),
    .k_i    (step_q),
    .sel_i  (n_q[step_q]),
    .fill_i (b_q),
    .acc_o  (step_acc)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    step_d   = step_q;
    n_d      = n_q;
    b_d      = b_q;
    ovfp_d   = ovfp_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d     = (bus.count > WMAX) ? WMAX : bus.count;
          b_d     = bus.lead_bit;
          ovfp_d  = (bus.count > WMAX);
          acc_d   = {WIDTH{~bus.lead_bit}};
          step_d  = KW'(CW-1);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_acc;
        // Step 0 commits straight from the stage output so no extra cycle is spent.
        if (step_q == '0) begin
          result_d = step_acc;
          ovf_d    = ovfp_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          step_d = step_q - KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      step_q   <= '0;
      n_q      <= '0;
      b_q      <= 1'b0;
      ovfp_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      n_q      <= n_d;
      b_q      <= b_d;
      ovfp_q   <= ovfp_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_cl_mask_gen.sv
// Scoreboard bench for cl_mask_gen: directed requests push expectations,
// a negedge monitor pops and checks on every done pulse.
module tb_cl_mask_gen;
  import cl_pkg::*;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             ovf;
    int unsigned      n;
    logic             b;
    int unsigned      cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  exp_t sb[$];

  cl_mask_gen_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  cl_mask_gen #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 64'(bus.result), 64'(e.res));
        chk("ovf", 64'(bus.ovf), 64'(e.ovf));
        chk("latency", 64'(cyc), 64'(e.cyc));
        chk("round_trip", 64'(count_ref(bus.result, e.b)), 64'(e.n));
      end
    end
  end

  task automatic wait_ready();
    int unsigned guard;
    guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.ready) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  // Issue one request; returns after the accepting edge.
  task automatic issue(input int unsigned cnt, input logic b, input logic [WIDTH-1:0] res,
                       input logic ov, input logic push, input logic keep);
    exp_t e;
    wait_ready();
    bus.start    = 1'b1;
    bus.count    = CW'(cnt);
    bus.lead_bit = b;
    @(posedge clk);
    #1;
    if (push) begin
      e.res = res;
      e.ovf = ov;
      e.n   = (cnt > WIDTH) ? WIDTH : cnt;
      e.b   = b;
      e.cyc = cyc + CW;
      sb.push_back(e);
    end
    if (!keep) bus.start = 1'b0;
  endtask

  task automatic drain();
    int unsigned guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] m;
    bus.start = 1'b0;
    bus.count = '0;
    bus.lead_bit = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);

    issue(0,  1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0);
    issue(0,  1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    issue(5,  1'b1, 32'hF8000000, 1'b0, 1'b1, 1'b0);
    issue(5,  1'b0, 32'h07FFFFFF, 1'b0, 1'b1, 1'b0);
    issue(32, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    issue(32, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0);
    issue(40, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
    issue(31, 1'b0, 32'h00000001, 1'b0, 1'b1, 1'b0);
    issue(63, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0);
    drain();

    // Back-to-back with start held high throughout.
    issue(1, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b1);
    issue(2, 1'b1, 32'hC0000000, 1'b0, 1'b1, 1'b1);
    issue(3, 1'b1, 32'hE0000000, 1'b0, 1'b1, 1'b1);
    bus.start = 1'b0;
    drain();

    // start pulses while RUN must be ignored; result must hold meanwhile.
    issue(7, 1'b0, 32'h01FFFFFF, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.count = CW'(12);
    bus.lead_bit = 1'b1;
    @(negedge clk);
    chk("hold_result", 64'(bus.result), 64'hE0000000);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (10) @(negedge clk);

    // Reset during step 2 (after edges E+1..E+3): aborts with no done.
    issue(9, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_result", 64'(bus.result), 64'd0);
    chk("mid_rst_ready", 64'(bus.ready), 64'd1);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_result", 64'(bus.result), 64'd0);
    chk("post_rst_ready", 64'(bus.ready), 64'd1);

    // Round-trip sweep over every count and polarity.
    for (int unsigned b = 0; b < 2; b++) begin
      for (int unsigned n = 0; n <= WIDTH; n++) begin
        for (int unsigned i = 0; i < WIDTH; i++)
          m[i] = (i >= WIDTH - n) ? b[0] : ~b[0];
        issue(n, b[0], m, 1'b0, 1'b1, 1'b0);
      end
    end
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/cl_mask_gen.md
Name: cl_mask_gen

Overview:
- Inverse of the count-leading-ones/zeros unit. It takes a leading-bit count n and a polarity bit. It produces the canonical word: n leading copies of the polarity bit, followed by its complement in every remaining position.
- Used by the ALU/EX stage for mask construction (INS/EXT-style field masks). The verification bench uses it as the round-trip partner of the CLO/CLZ unit.
- Iterative and multi-cycle: one count bit is resolved per cycle, MSB first, walking the same binary tree the counter walks.

Parameters:
- WIDTH, 32, result width; must be a power of two.
- CW, 6, count width, equal to log2(WIDTH)+1; covers 0..WIDTH.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request; sampled only while ready=1.
- count  in  CW  requested leading-bit count n.
- bit  in  1  polarity: 1 = leading ones (CLO sense), 0 = leading zeros (CLZ sense).
- ready  out  1  idle; a start will be accepted this cycle.
- done  out  1  one-cycle pulse; result is valid and updated.
- result  out  WIDTH  generated word, held until the next completion.
- ovf  out  1  count exceeded WIDTH and was clamped; valid with done, held with result.

Behaviour:
- Reset (async, any state) sets: state=IDLE, ready=1, done=0, result=0, ovf=0, internal accumulator=0, step=0.
- States are IDLE and RUN. ready=1 exactly when state=IDLE.
- Accept at edge E when state=IDLE and start=1:
  - latch n_eff = min(count, WIDTH) and latch bit;
  - latch ovf_pending = (count > WIDTH);
  - acc <= all bits ~bit;
  - step <= CW-1;
  - state <= RUN.
- RUN, one step per edge, for step k = CW-1 down to 0:
  - if n_eff[k]=1, acc <= acc shifted right by 2^k, vacated MSBs filled with bit;
  - otherwise acc is unchanged.
  - Step k=CW-1 (shift by WIDTH) only occurs when n_eff=WIDTH, and makes acc all bit.
- After step 0 (edge E+CW):
  - result <= final acc value;
  - ovf <= ovf_pending;
  - done <= 1 for exactly one cycle;
  - state <= IDLE.
- Fixed latency: done is high in the cycle following edge E+CW, i.e. CW cycles after start is sampled, for every n including 0 and WIDTH. There is no fast path.
- Back-to-back requests: ready=1 in the same cycle as done, so a start presented with done is accepted. Throughput is one result per CW+1 cycles.
- start while RUN is ignored, with no queuing. count and bit are don't-care except at accept.
- result and ovf change only at completion or reset. They stay stable while RUN.
- Reset mid-RUN aborts with no done pulse, and result returns to 0.
- Functional definition (for the checker):
  - result[WIDTH-1 -: n_eff] = bit;
  - result[WIDTH-1-n_eff : 0] = ~bit;
  - feeding result with the same bit into the leading-bit counter returns n_eff.

Decomposition:
- Shared package cl_pkg holds:
  - WIDTH and CW constants;
  - the state enum {IDLE, RUN};
  - a function count_ref(value, bit) for bench reference use.
- One natural combinational sub-module, cl_mask_step. It takes acc, k, n_eff[k] and bit, and returns the shifted acc (barrel stage selected by k). The FSM, step counter and output registers stay in cl_mask_gen.

Test Plan:
- Reset then idle: after rst deassert, ready=1, done=0, result=0x00000000, ovf=0. Assert rst during RUN step 2: no done, result=0, ready=1 next cycle.
- start, count=0, bit=1: done 6 cycles later with result=0x00000000. Same with bit=0: result=0xFFFFFFFF, ovf=0.
- start, count=5, bit=1 -> result=0xF8000000. count=5, bit=0 -> result=0x07FFFFFF. count=32, bit=1 -> 0xFFFFFFFF. count=32, bit=0 -> 0x00000000.
- start, count=40, bit=1 -> result=0xFFFFFFFF with ovf=1. Next request count=31, bit=0 -> result=0x00000001 with ovf=0.
- Back-to-back: start held high continuously with count 1, 2, 3, bit=1 -> done pulses 7 cycles apart, results 0x80000000, 0xC0000000, 0xE0000000. start pulses during RUN produce no extra done.
- Round-trip sweep: for all n in 0..32 and bit in {0,1}, feed result into the leading-bit counter -> its count equals n.
